// File: rtl/dmem_ctrl.sv
// Byte-addressable little-endian data memory with req/ready handshake,
// programmable wait states and alignment/range checking.
module dmem_ctrl #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        addr_error,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] LAST = 4'((WAIT > 0) ? WAIT - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_ST = 2'd1, DONE = 2'd2} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [7:0]          mem [DEPTH];

  logic                r_we;
  logic [1:0]          r_size;
  logic                r_sext;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;

  // Handshake: a request is taken on any rising edge where req=1 and the
  // FSM is in IDLE or DONE; completion is a one-cycle ready pulse, with
  // addr_error qualifying it. req is ignored while busy.
  logic                accepting, in_err, do_access;
  logic                a_we, a_sext;
  logic [1:0]          a_size;
  logic [ADDR_W-1:0]   a0, a1, a2, a3;
  logic [31:0]         a_wdata;
  logic [7:0]          b0, b1, b2, b3;
  logic [31:0]         ld_val;

  function automatic logic is_err(input logic [1:0] sz, input logic [31:0] ad);
    return (sz == 2'b11) ||
           (sz == 2'b10 && ad[1:0] != 2'b00) ||
           (sz == 2'b01 && ad[0]) ||
           ((ad >> ADDR_W) != 32'd0);
  endfunction

  assign accepting = (state == IDLE) || (state == DONE);
  assign in_err    = is_err(size, addr);
  assign dbg_state = state;

  // With zero wait states the access happens on the acceptance edge, so the
  // live inputs are used; otherwise the registered copy drives it.
  always_comb begin
    a_we    = we;
    a_size  = size;
    a_sext  = sign_ext;
    a0      = addr[ADDR_W-1:0];
    a_wdata = wdata;
    if (state == WAIT_ST) begin
      a_we    = r_we;
      a_size  = r_size;
      a_sext  = r_sext;
      a0      = r_addr;
      a_wdata = r_wdata;
    end
  end

  assign a1 = a0 + ADDR_W'(1);
  assign a2 = a0 + ADDR_W'(2);
  assign a3 = a0 + ADDR_W'(3);

  assign do_access = ((WAIT == 0) && accepting && req && !in_err) ||
                     ((state == WAIT_ST) && (cnt == LAST));

  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    ld_val = {b3, b2, b1, b0};
    case (a_size)
      2'b00:   ld_val = a_sext ? {{24{b0[7]}}, b0} : {24'h0, b0};
      2'b01:   ld_val = a_sext ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
      default: ld_val = {b3, b2, b1, b0};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      rdata      <= 32'h0;
      ready      <= 1'b0;
      addr_error <= 1'b0;
      busy       <= 1'b0;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_sext     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      ready      <= 1'b0;
      addr_error <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (req) begin
            r_we    <= we;
            r_size  <= size;
            r_sext  <= sign_ext;
            r_addr  <= addr[ADDR_W-1:0];
            r_wdata <= wdata;
            if (in_err) begin
              state      <= DONE;
              ready      <= 1'b1;
              addr_error <= 1'b1;
              rdata      <= 32'h0;
            end else if (WAIT == 0) begin
              state <= DONE;
            end else begin
              state <= WAIT_ST;
              cnt   <= 4'd0;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT_ST: begin
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (do_access) begin
        ready <= 1'b1;
        if (a_we) begin
          mem[a0] <= a_wdata[7:0];
          if (a_size != 2'b00) mem[a1] <= a_wdata[15:8];
          if (a_size == 2'b10) begin
            mem[a2] <= a_wdata[23:16];
            mem[a3] <= a_wdata[31:24];
          end
        end else begin
          rdata <= ld_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl (ADDR_W=10, WAIT=2): directed accesses,
// error cases, reset abort and a randomised sweep against a byte model.
module tb_dmem_ctrl;

  localparam int ADDR_W = 10;
  localparam int WAIT   = 2;

  logic        clk, reset, req, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        ready, addr_error, busy;
  logic [1:0]  dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  logic [32:0] exp_q[$];
  logic [7:0]  mdl [0:1023];
  logic [31:0] mdl_rdata;

  dmem_ctrl #(.ADDR_W(ADDR_W), .WAIT(WAIT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rdata(rdata),
    .ready(ready), .addr_error(addr_error), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic mdl_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd2 && a[1:0] != 2'd0) ||
           (sz == 2'd1 && a[0] != 1'b0) || (a >= 32'd1024);
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < 1024; i++) mdl[i] = 8'h00;
    mdl_rdata = 32'h0;
  endtask

  // Applies the access to the model and returns {err, rdata} it predicts.
  task automatic mdl_apply(input logic w, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] d,
                           output logic [32:0] res);
    logic [9:0] i;
    logic [31:0] v;
    i = a[9:0];
    if (mdl_err(sz, a)) begin
      mdl_rdata = 32'h0;
      res = {1'b1, 32'h0};
      return;
    end
    if (w) begin
      if (sz == 2'd0) mdl[i] = d[7:0];
      else if (sz == 2'd1) begin mdl[i] = d[7:0]; mdl[i+1] = d[15:8]; end
      else for (int k = 0; k < 4; k++) mdl[i+10'(k)] = d[8*k +: 8];
    end else begin
      if (sz == 2'd0) begin
        v = {24'h0, mdl[i]};
        if (sx && v[7]) v[31:8] = 24'hFFFFFF;
      end else if (sz == 2'd1) begin
        v = {16'h0, mdl[i+1], mdl[i]};
        if (sx && v[15]) v[31:16] = 16'hFFFF;
      end else begin
        v = {mdl[i+3], mdl[i+2], mdl[i+1], mdl[i]};
      end
      mdl_rdata = v;
    end
    res = {1'b0, mdl_rdata};
  endtask

  // driver: one access, with latency and busy-length checks
  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic use_want, input logic [31:0] want);
    logic [32:0] res;
    logic        err;
    int          n, nbusy;
    bit          seen;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    @(posedge clk);
    mdl_apply(w, sz, sx, a, d, res);
    err = res[32];
    if (use_want) res[31:0] = want;
    exp_q.push_back(res);
    n = 0; nbusy = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      req = 1'b0;
      n++;
      if (busy) nbusy++;
      if (ready) seen = 1;
    end
    if (!seen) check("timeout", 32'd0, 32'd1);
    check("latency", 32'(n), err ? 32'd1 : 32'(WAIT + 1));
    check("busy_len", 32'(nbusy), err ? 32'd0 : 32'(WAIT));
  endtask

  // scoreboard
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset && ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_ready", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rdata", rdata, e[31:0]);
        check("addr_error", 32'(addr_error), 32'(e[32]));
      end
    end
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    req = 0; we = 0; size = 0; sign_ext = 0; addr = 0; wdata = 0;
    mdl_clear();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_err", 32'(addr_error), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    reset = 1'b0;

    access(0, 2'd2, 0, 32'h10, 0, 1, 32'h00000000);
    access(1, 2'd2, 0, 32'h20, 32'h8899AABB, 1, 32'h00000000);
    access(0, 2'd2, 0, 32'h20, 0, 1, 32'h8899AABB);
    access(0, 2'd0, 0, 32'h20, 0, 1, 32'h000000BB);
    access(0, 2'd0, 0, 32'h23, 0, 1, 32'h00000088);
    access(1, 2'd0, 0, 32'h21, 32'h000000F0, 1, 32'h00000088);
    access(0, 2'd2, 0, 32'h20, 0, 1, 32'h8899F0BB);
    access(0, 2'd0, 1, 32'h21, 0, 1, 32'hFFFFFFF0);
    access(0, 2'd0, 0, 32'h21, 0, 1, 32'h000000F0);
    access(1, 2'd1, 0, 32'h22, 32'h00001234, 1, 32'h000000F0);
    access(0, 2'd1, 1, 32'h22, 0, 1, 32'h00001234);
    access(0, 2'd2, 0, 32'h20, 0, 1, 32'h1234F0BB);

    access(1, 2'd2, 0, 32'h21, 32'hCAFEF00D, 1, 32'h0);
    access(0, 2'd2, 0, 32'h20, 0, 1, 32'h1234F0BB);
    access(0, 2'd1, 0, 32'h23, 0, 1, 32'h0);
    access(0, 2'd2, 0, 32'h20, 0, 1, 32'h1234F0BB);
    access(1, 2'd3, 0, 32'h20, 32'h55555555, 1, 32'h0);
    access(0, 2'd2, 0, 32'h20, 0, 1, 32'h1234F0BB);
    access(0, 2'd2, 0, 32'h400, 0, 1, 32'h0);
    access(0, 2'd2, 0, 32'h20, 0, 1, 32'h1234F0BB);

    // reset during WAIT_ST aborts a store
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; sign_ext = 1'b0;
    addr = 32'h30; wdata = 32'hDEADBEEF;
    @(negedge clk);
    req = 1'b0;
    check("abort_busy_pre", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_ready", 32'(ready), 32'h0);
    check("abort_rdata", rdata, 32'h0);
    check("abort_state", 32'(dbg_state), 32'h0);
    exp_q.delete();
    mdl_clear();
    @(negedge clk);
    reset = 1'b0;
    access(0, 2'd2, 0, 32'h30, 0, 1, 32'h00000000);
    access(0, 2'd2, 0, 32'h20, 0, 1, 32'h00000000);

    // randomised sweep against the byte model
    for (int t = 0; t < 60; t++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = a + 32'h400;
      if ($urandom_range(0, 2) != 0 && sz == 2'd2) a[1:0] = 2'b00;
      if ($urandom_range(0, 2) != 0 && sz == 2'd1) a[0] = 1'b0;
      access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
             $urandom(), 0, 32'h0);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
